// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with per-digit moduli, edge-detected add/sub,
// synchronous load and a roll-over pulse. Define BCD_COUNTER_SAT_EN for saturating mode.
module bcd_updown_counter #(
  parameter int DIGITS = 4,
  parameter int MOD_LO = 10,
  parameter int MOD_HI = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  add,
  input  logic                  sub,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic [4*DIGITS-1:0]   QnR,
  output logic                  wrap,
  output logic                  zero
);

  localparam int W = 4 * DIGITS;

  // Even-indexed digits use MOD_LO, odd-indexed digits use MOD_HI.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx % 2 == 0) ? 4'(MOD_LO - 1) : 4'(MOD_HI - 1);
  endfunction

  logic         add_q, sub_q;
  logic         inc, dec;
  logic [W-1:0] q_inc, q_dec, load_clean;
  logic         all_max, all_zero;
  logic         carry, borrow;

  assign inc = add & ~add_q;
  assign dec = sub & ~sub_q;

  // Carry and borrow ripple from digit 0 upward within a single cycle.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_inc      = '0;
    q_dec      = '0;
    load_clean = '0;
    carry      = 1'b1;
    borrow     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry)
        q_inc[4*i +: 4] = (Q[4*i +: 4] == digit_max(i)) ? 4'd0 : Q[4*i +: 4] + 4'd1;
      else
        q_inc[4*i +: 4] = Q[4*i +: 4];

      if (borrow)
        q_dec[4*i +: 4] = (Q[4*i +: 4] == 4'd0) ? digit_max(i) : Q[4*i +: 4] - 4'd1;
      else
        q_dec[4*i +: 4] = Q[4*i +: 4];

      load_clean[4*i +: 4] = (load_val[4*i +: 4] > digit_max(i)) ? 4'd0 : load_val[4*i +: 4];

      carry  = carry  & (Q[4*i +: 4] == digit_max(i));
      borrow = borrow & (Q[4*i +: 4] == 4'd0);
    end
    all_max  = carry;
    all_zero = borrow;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q     <= '0;
      wrap  <= 1'b0;
      add_q <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      add_q <= add;
      sub_q <= sub;
      wrap  <= 1'b0;
      if (load) begin
        Q <= load_clean;
      end else if (inc && !dec) begin
`ifdef BCD_COUNTER_SAT_EN
        if (!all_max) Q <= q_inc;
`else
        Q    <= q_inc;
        wrap <= all_max;
`endif
      end else if (dec && !inc) begin
`ifdef BCD_COUNTER_SAT_EN
        if (!all_zero) Q <= q_dec;
`else
        Q    <= q_dec;
        wrap <= all_zero;
`endif
      end
    end
  end

  assign QnR  = reset ? '0 : ~Q;
  assign zero = (Q == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a mixed-radix integer model predicts each
// cycle's outputs, and a monitor compares them one time step after every rising edge.
module tb_bcd_updown_counter;

  localparam int DIGITS = 4;
  localparam int MOD_LO = 10;
  localparam int MOD_HI = 6;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset, add, sub, load;
  logic [W-1:0] load_val;
  logic [W-1:0] Q, QnR;
  logic         wrap, zero;

  bcd_updown_counter #(.DIGITS(DIGITS), .MOD_LO(MOD_LO), .MOD_HI(MOD_HI)) dut (
    .clk(clk), .reset(reset), .add(add), .sub(sub), .load(load),
    .load_val(load_val), .Q(Q), .QnR(QnR), .wrap(wrap), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] qnr;
    logic         wrap;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: the count as a plain integer in mixed radix, plus previous request levels.
  int   mv    = 0;
  bit   m_wrap = 0;
  bit   pa    = 0;
  bit   ps    = 0;

  function automatic int modulus(input int i);
    return (i % 2 == 0) ? MOD_LO : MOD_HI;
  endfunction

  function automatic int span();
    int t = 1;
    for (int i = 0; i < DIGITS; i++) t = t * modulus(i);
    return t;
  endfunction

  // Digits at or above their modulus load as 0.
  function automatic int bcd_to_int(input logic [W-1:0] bcd);
    int v = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(bcd[4*i +: 4]);
      if (d >= modulus(i)) d = 0;
      v = v + d * w;
      w = w * modulus(i);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] b = '0;
    int r = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % modulus(i));
      r = r / modulus(i);
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit a, input bit s, input bit l, input logic [W-1:0] lv);
    bit inc, dec;
    if (r) begin
      mv = 0; m_wrap = 0; pa = 0; ps = 0;
      return;
    end
    inc = a && !pa;
    dec = s && !ps;
    pa = a;
    ps = s;
    m_wrap = 0;
    if (l) begin
      mv = bcd_to_int(lv);
    end else if (inc && !dec) begin
`ifdef BCD_COUNTER_SAT_EN
      if (mv < span() - 1) mv = mv + 1;
`else
      m_wrap = (mv == span() - 1);
      mv = (mv + 1) % span();
`endif
    end else if (dec && !inc) begin
`ifdef BCD_COUNTER_SAT_EN
      if (mv > 0) mv = mv - 1;
`else
      m_wrap = (mv == 0);
      mv = (mv + span() - 1) % span();
`endif
    end
  endtask

  // Drive one cycle at the falling edge and queue what the next rising edge must produce.
  task automatic step(input bit r, input bit a, input bit s, input bit l, input logic [W-1:0] lv);
    exp_t e;
    @(negedge clk);
    reset = r; add = a; sub = s; load = l; load_val = lv;
    model(r, a, s, l, lv);
    e.q    = int_to_bcd(mv);
    e.qnr  = r ? '0 : ~int_to_bcd(mv);
    e.wrap = m_wrap;
    e.zero = (mv == 0);
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Directed spot check of an absolute expected value just after the edge.
  task automatic spot(input string name, input logic [W-1:0] exp_q, input bit exp_w);
    #2;
    check({name, ".q"}, Q, exp_q);
    check({name, ".wrap"}, wrap, exp_w);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("Q", Q, e.q);
      check("QnR", QnR, e.qnr);
      check("wrap", wrap, e.wrap);
      check("zero", zero, e.zero);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] lv;
    reset = 1'b1; add = 1'b0; sub = 1'b0; load = 1'b0; load_val = '0;

    // Reset while add is held, then release with add still high.
    step(1, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    #2 check("reset.qnr", QnR, 16'h0000);
    check("reset.zero", zero, 1'b1);
    step(0, 1, 0, 0, '0);
    spot("post_reset_inc", 16'h0001, 0);
    step(0, 0, 0, 0, '0);

    // Carry ripple and held add.
    step(0, 0, 0, 1, 16'h0959);
    step(0, 1, 0, 0, '0);
    spot("ripple", 16'h1000, 0);
    repeat (5) step(0, 1, 0, 0, '0);
    spot("held_add", 16'h1000, 0);
    step(0, 0, 0, 0, '0);

    // Increment at all-max.
    step(0, 0, 0, 1, 16'h5959);
    step(0, 1, 0, 0, '0);
`ifdef BCD_COUNTER_SAT_EN
    spot("top", 16'h5959, 0);
    step(0, 0, 0, 1, 16'h0000);
`else
    spot("top", 16'h0000, 1);
    step(0, 0, 0, 0, '0);
    spot("wrap_one_cycle", 16'h0000, 0);
`endif

    // Decrement at all-zero, then simultaneous edges.
    step(0, 0, 1, 0, '0);
`ifdef BCD_COUNTER_SAT_EN
    spot("bottom", 16'h0000, 0);
`else
    spot("bottom", 16'h5959, 1);
`endif
    step(0, 0, 0, 0, '0);
    step(0, 1, 1, 0, '0);
`ifdef BCD_COUNTER_SAT_EN
    spot("both", 16'h0000, 0);
`else
    spot("both", 16'h5959, 0);
`endif
    step(0, 0, 0, 0, '0);

    // Out-of-range load digits, and an edge swallowed by load.
    step(0, 0, 0, 1, 16'h7A3C);
    spot("sanitize", 16'h0030, 0);
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 1, 16'h7A3C);
    step(0, 1, 0, 0, '0);
    spot("load_eats_edge", 16'h0030, 0);

    // Randomized traffic with biased loads near the boundaries.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(3))
        0: lv = 16'h5959;
        1: lv = 16'h0000;
        2: lv = 16'h5958;
        default: lv = W'($urandom);
      endcase
      step($urandom_range(99) == 0, $urandom_range(1) == 1, $urandom_range(2) == 0,
           $urandom_range(15) == 0, lv);
    end

    repeat (3) step(0, 0, 0, 0, '0);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Multi-digit BCD up/down counter for the timekeeping datapath, e.g. an MM:SS display.
- Replaces per-digit combinational adder cells with one registered, parametrised block.
- Each digit has its own modulus, so a single instance counts 0..59 per digit pair.
- add/sub requests are edge-detected; a held button advances exactly one step.

Parameters:
DIGITS, 4, number of BCD digits; digit 0 is least significant; range 1..8
MOD_LO, 10, modulus of even-indexed digits (0,2,...); range 2..10
MOD_HI, 6, modulus of odd-indexed digits (1,3,...); range 2..10

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
add  input  1  increment request, level; acted on at rising edge only
sub  input  1  decrement request, level; acted on at rising edge only
load  input  1  synchronous load of load_val, level-sensitive
load_val  input  4*DIGITS  BCD value to load; digit i in bits [4i+3:4i]
Q  output  4*DIGITS  current BCD count
QnR  output  4*DIGITS  bitwise complement of Q; forced all-zero while reset is high
wrap  output  1  one-cycle pulse on roll-over 0->max or max->0
zero  output  1  high when every digit of Q is 0

Behaviour:
- Reset (sync, active-high) takes effect on the clock edge where it is sampled high:
  - Q=0, wrap=0, edge-detect registers add_q=0 and sub_q=0.
  - zero=1.
  - QnR=0 combinationally while reset is high; otherwise QnR = ~Q.
  - Reset overrides load, add and sub.
- Edge detect:
  - inc = add & ~add_q
  - dec = sub & ~sub_q
  - add_q and sub_q are registered every cycle, including cycles with load active.
- Priority per cycle: reset > load > step.
- Load: Q <= load_val at the next edge; wrap=0.
  - Any load_val digit >= its modulus is replaced by 0 for that digit only.
  - Edges occurring in the same cycle as load are consumed and discarded.
- Step:
  - inc & ~dec: increment by 1.
  - dec & ~inc: decrement by 1.
  - inc & dec: no change, wrap=0.
  - Neither: hold.
- Increment:
  - Digit i increments if all lower digits equal max_i (= MOD_i - 1).
  - A digit at max becomes 0; the carry ripples combinationally within one cycle.
- Decrement:
  - Digit i decrements if all lower digits equal 0.
  - A digit at 0 becomes max_i.
- Latency: Q updates on the edge that samples the request edge, i.e. one cycle after add rises.
- wrap:
  - Registered; high for exactly the one cycle in which Q shows the wrapped value.
  - Increment from all-max sets wrap=1; Q becomes 0.
  - Decrement from all-zero sets wrap=1; Q becomes all-max.
- Holding add high for N cycles gives exactly one step. Releasing and re-asserting add gives another step.
- Reset mid-hold: add_q clears. If add is still high on the first cycle after reset, that counts as a new edge and produces one increment.
- zero is combinational from Q.

Optional Feature:
- Macro: BCD_COUNTER_SAT_EN
- Defined: saturating mode.
  - Increment at all-max holds Q; decrement at all-zero holds Q.
  - wrap never asserts (tied 0).
- Not defined: wrap-around as described above.

Test Plan (DIGITS=4, MOD_LO=10, MOD_HI=6 unless noted):
1. Assert reset with add=1 held high -> Q=0x0000, QnR=0x0000 during reset, zero=1, wrap=0. After reset drops with add still high: one increment, Q=0x0001.
2. Load 0x0959, then pulse add one cycle -> Q=0x1000, wrap=0. Hold add high 5 cycles -> Q stays 0x1000.
3. Load 0x5959, rising edge on add -> next cycle Q=0x0000, wrap=1 for exactly one cycle, zero=1.
4. From Q=0x0000, rising edge on sub -> Q=0x5959, wrap=1. Then edges on add and sub in the same cycle -> Q unchanged, wrap=0.
5. Load 0x7A3C -> Q=0x0030, since digits 7, A and C exceed their moduli. Load held high together with an add edge -> Q=0x0030, no step.
6. With BCD_COUNTER_SAT_EN defined: load 0x5959, add edge -> Q=0x5959, wrap=0. Load 0x0000, sub edge -> Q=0x0000, wrap=0.
